// File: rtl/rv32i_id_stage_if.sv
// Handshake bundle between fetch, the RV32I decode stage and execute.
// The decode stage takes the slave view; the fetch/execute side takes master.
interface rv32i_id_stage_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [31:0] id_imm;
  logic [3:0]  id_class;
  logic [3:0]  id_alu_op;
  logic        id_rd_we;
  logic        id_illegal;

  modport master (
    output fetch_valid, fetch_pc, fetch_instr, id_ready,
    input  fetch_ready, id_valid, id_pc, id_instr, id_rs1, id_rs2, id_rd,
           id_imm, id_class, id_alu_op, id_rd_we, id_illegal
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_instr, id_ready,
    output fetch_ready, id_valid, id_pc, id_instr, id_rs1, id_rs2, id_rd,
           id_imm, id_class, id_alu_op, id_rd_we, id_illegal
  );
endinterface

// File: rtl/rv32i_id_stage.sv
// RV32I decode stage: holds one fetched {pc, instr} and decodes it
// combinationally into register indices, immediate, ALU op and class.
// Optional feature macro RV32I_ID_SKID_EN adds a skid entry so that
// fetch_ready has no combinational path from id_ready.
module rv32i_id_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk_i,
  input logic              rst_ni,
  input logic              stall_i,
  input logic              flush_i,
  rv32i_id_stage_if.slave  bus
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_FENCE  = 7'h0F;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [3:0] CL_OP = 4'd0, CL_OP_IMM = 4'd1, CL_LUI = 4'd2, CL_AUIPC = 4'd3;
  localparam logic [3:0] CL_JAL = 4'd4, CL_JALR = 4'd5, CL_BRANCH = 4'd6, CL_LOAD = 4'd7;
  localparam logic [3:0] CL_STORE = 4'd8, CL_FENCE = 4'd9, CL_ECALL = 4'd10, CL_EBREAK = 4'd11;
  localparam logic [3:0] CL_ILLEGAL = 4'd15;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam logic [3:0] ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  // Immediate extraction, one function per encoding format.
  function automatic logic signed [31:0] imm_i(input logic [31:0] ir);
    return $signed({{20{ir[31]}}, ir[31:20]});
  endfunction
  function automatic logic signed [31:0] imm_s(input logic [31:0] ir);
    return $signed({{20{ir[31]}}, ir[31:25], ir[11:7]});
  endfunction
  function automatic logic signed [31:0] imm_b(input logic [31:0] ir);
    return $signed({{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0});
  endfunction
  function automatic logic signed [31:0] imm_u(input logic [31:0] ir);
    return $signed({ir[31:12], 12'b0});
  endfunction
  function automatic logic signed [31:0] imm_j(input logic [31:0] ir);
    return $signed({{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0});
  endfunction

  // Register/immediate ALU op; alt selects SUB/SRA.
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic        vld_p0;
  logic [31:0] pc_p0;
  logic [31:0] instr_p0;
  logic        in_fire;
  logic        out_fire;

  assign in_fire  = bus.fetch_valid & bus.fetch_ready;
  assign out_fire = vld_p0 & bus.id_ready & ~stall_i;

`ifdef RV32I_ID_SKID_EN
  logic        skid_vld_p0;
  logic [31:0] skid_pc_p0;
  logic [31:0] skid_instr_p0;

  assign bus.fetch_ready = ~stall_i & ~flush_i & ~skid_vld_p0;

  // Main and skid occupancy; skid drains into main whenever execute takes main.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0      <= 1'b0;
      pc_p0       <= RESET_PC;
      instr_p0    <= NOP_INSTR;
      skid_vld_p0 <= 1'b0;
    end else if (flush_i) begin
      vld_p0      <= 1'b0;
      skid_vld_p0 <= 1'b0;
    end else if (out_fire) begin
      if (skid_vld_p0) begin
        pc_p0       <= skid_pc_p0;
        instr_p0    <= skid_instr_p0;
        skid_vld_p0 <= 1'b0;
      end else if (in_fire) begin
        pc_p0    <= bus.fetch_pc;
        instr_p0 <= bus.fetch_instr;
      end else begin
        vld_p0 <= 1'b0;
      end
    end else if (in_fire) begin
      if (!vld_p0) begin
        vld_p0   <= 1'b1;
        pc_p0    <= bus.fetch_pc;
        instr_p0 <= bus.fetch_instr;
      end else begin
        skid_vld_p0 <= 1'b1;
      end
    end
  end

  // Skid payload captures input only when main is full and not draining.
  always_ff @(posedge clk_i) begin
    if (in_fire & vld_p0 & ~out_fire) begin
      skid_pc_p0    <= bus.fetch_pc;
      skid_instr_p0 <= bus.fetch_instr;
    end
  end
`else
  assign bus.fetch_ready = ~stall_i & ~flush_i & (~vld_p0 | bus.id_ready);

  // Single holding register: flush, then load, then drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_p0   <= 1'b0;
      pc_p0    <= RESET_PC;
      instr_p0 <= NOP_INSTR;
    end else if (flush_i) begin
      vld_p0 <= 1'b0;
    end else if (in_fire) begin
      vld_p0   <= 1'b1;
      pc_p0    <= bus.fetch_pc;
      instr_p0 <= bus.fetch_instr;
    end else if (out_fire) begin
      vld_p0 <= 1'b0;
    end
  end
`endif

  // ---- decode of the held instruction ----
  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic [3:0]         cls;
  logic [3:0]         alu;
  logic signed [31:0] imm;

  assign opc = instr_p0[6:0];
  assign f3  = instr_p0[14:12];
  assign f7  = instr_p0[31:25];

  // Class, ALU op and immediate; opcode match also enforces instr[1:0]==2'b11.
  always_comb begin
    cls = CL_ILLEGAL;
    alu = ALU_ADD;
    imm = '0;
    case (opc)
      OPC_LUI:   begin cls = CL_LUI;   alu = ALU_PASSB; imm = imm_u(instr_p0); end
      OPC_AUIPC: begin cls = CL_AUIPC; imm = imm_u(instr_p0); end
      OPC_JAL:   begin cls = CL_JAL;   imm = imm_j(instr_p0); end
      OPC_JALR:  if (f3 == 3'd0) begin cls = CL_JALR; imm = imm_i(instr_p0); end
      OPC_BRANCH: begin
        if (f3 != 3'd2 && f3 != 3'd3) begin
          cls = CL_BRANCH;
          imm = imm_b(instr_p0);
          alu = (f3[2:1] == 2'b10) ? ALU_SLT : (f3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
        end
      end
      OPC_LOAD:  if (f3 != 3'd3 && f3 < 3'd6) begin cls = CL_LOAD; imm = imm_i(instr_p0); end
      OPC_STORE: if (f3 <= 3'd2) begin cls = CL_STORE; imm = imm_s(instr_p0); end
      OPC_OP_IMM: begin
        if ((f3 != 3'd1 || f7 == 7'h00) &&
            (f3 != 3'd5 || f7 == 7'h00 || f7 == 7'h20)) begin
          cls = CL_OP_IMM;
          imm = imm_i(instr_p0);
          alu = alu_from_f3(f3, (f3 == 3'd5) & f7[5]);
        end
      end
      OPC_OP: begin
        if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) begin
          cls = CL_OP;
          alu = alu_from_f3(f3, f7[5]);
        end
      end
      OPC_FENCE: cls = CL_FENCE;
      OPC_SYSTEM: begin
        if (instr_p0 == 32'h0000_0073)      cls = CL_ECALL;
        else if (instr_p0 == 32'h0010_0073) cls = CL_EBREAK;
      end
      default: cls = CL_ILLEGAL;
    endcase
  end

  assign bus.id_valid   = vld_p0;
  assign bus.id_pc      = pc_p0;
  assign bus.id_instr   = instr_p0;
  assign bus.id_rs1     = instr_p0[19:15];
  assign bus.id_rs2     = instr_p0[24:20];
  assign bus.id_rd      = instr_p0[11:7];
  assign bus.id_imm     = imm;
  assign bus.id_class   = cls;
  assign bus.id_alu_op  = alu;
  assign bus.id_illegal = (cls == CL_ILLEGAL);
  assign bus.id_rd_we   = (instr_p0[11:7] != 5'd0) &&
                          (cls == CL_OP || cls == CL_OP_IMM || cls == CL_LUI ||
                           cls == CL_AUIPC || cls == CL_JAL || cls == CL_JALR ||
                           cls == CL_LOAD);

endmodule

// File: tb/tb_rv32i_id_stage.sv
// Scoreboard bench for rv32i_id_stage. Build with +define+RV32I_ID_SKID_EN
// to exercise the skid-entry variant.
module tb_rv32i_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_1000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [3:0]  cls;
    logic [3:0]  alu;
    logic        we;
  } exp_t;

  logic clk;
  logic rst_n;
  logic stall;
  logic flush;
  int   n_tests;
  int   n_fail;
  bit   rnd_bp;
  exp_t tbl[$];
  exp_t sb[$];
  exp_t cur_exp;

  rv32i_id_stage_if bus ();

  rv32i_id_stage #(.RESET_PC(RST_PC)) dut (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .stall_i (stall),
    .flush_i (flush),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [31:0] instr, input logic [3:0] cls, input logic [3:0] alu,
                     input logic [31:0] imm, input logic we);
    exp_t e;
    e.pc = '0; e.instr = instr; e.cls = cls; e.alu = alu; e.imm = imm; e.we = we;
    tbl.push_back(e);
  endtask

  // Scoreboard: pop/compare on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (bus.id_valid && bus.id_ready && !stall) begin
          if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check_eq("pc",      bus.id_pc, e.pc);
            check_eq("instr",   bus.id_instr, e.instr);
            check_eq("rs1",     {27'b0, bus.id_rs1}, {27'b0, e.instr[19:15]});
            check_eq("rs2",     {27'b0, bus.id_rs2}, {27'b0, e.instr[24:20]});
            check_eq("rd",      {27'b0, bus.id_rd},  {27'b0, e.instr[11:7]});
            check_eq("imm",     bus.id_imm, e.imm);
            check_eq("class",   {28'b0, bus.id_class}, {28'b0, e.cls});
            check_eq("alu_op",  {28'b0, bus.id_alu_op}, {28'b0, e.alu});
            check_eq("rd_we",   {31'b0, bus.id_rd_we}, {31'b0, e.we});
            check_eq("illegal", {31'b0, bus.id_illegal}, {31'b0, (e.cls == 4'd15)});
          end
        end
        if (bus.fetch_valid && bus.fetch_ready) sb.push_back(cur_exp);
      end
    end
  end

  task automatic drive(input logic [31:0] pc, input int idx);
    cur_exp = tbl[idx];
    cur_exp.pc = pc;
    bus.fetch_pc = pc;
    bus.fetch_instr = tbl[idx].instr;
    bus.fetch_valid = 1'b1;
  endtask

  task automatic send(input logic [31:0] pc, input int idx);
    drive(pc, idx);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.fetch_ready) begin
        @(posedge clk); #1;
        bus.fetch_valid = 1'b0;
        if (rnd_bp) bus.id_ready = 1'($urandom_range(0, 1));
        return;
      end
      @(posedge clk); #1;
      if (rnd_bp) bus.id_ready = 1'($urandom_range(0, 1));
    end
    check_eq("send_timeout", 32'd1, 32'd0);
    bus.fetch_valid = 1'b0;
  endtask

  task automatic drain();
    bus.fetch_valid = 1'b0;
    bus.id_ready = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (sb.size() == 0) break;
    end
    check_eq("drain_sb", sb.size(), 32'd0);
    check_eq("drain_valid", {31'b0, bus.id_valid}, 32'd0);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; rnd_bp = 1'b0;
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    bus.fetch_valid = 1'b0; bus.fetch_pc = '0; bus.fetch_instr = '0; bus.id_ready = 1'b0;

    add(32'h00500093, 4'd1, 4'd0, 32'h5, 1'b1);        // 0 addi x1,x0,5
    add(32'h40208033, 4'd0, 4'd1, 32'h0, 1'b0);        // 1 sub x0,x1,x2
    add(32'hFE20AE23, 4'd8, 4'd0, 32'hFFFFFFFC, 1'b0); // 2 sw
    add(32'h00000000, 4'd15, 4'd0, 32'h0, 1'b0);       // 3
    add(32'h00200073, 4'd15, 4'd0, 32'h0, 1'b0);       // 4
    add(32'h123450B7, 4'd2, 4'd10, 32'h12345000, 1'b1);
    add(32'h00001117, 4'd3, 4'd0, 32'h00001000, 1'b1);
    add(32'h008000EF, 4'd4, 4'd0, 32'h8, 1'b1);
    add(32'hFFDFF0EF, 4'd4, 4'd0, 32'hFFFFFFFC, 1'b1);
    add(32'h000080E7, 4'd5, 4'd0, 32'h0, 1'b1);
    add(32'h000090E7, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'h00208463, 4'd6, 4'd1, 32'h8, 1'b0);
    add(32'h0020C463, 4'd6, 4'd3, 32'h8, 1'b0);
    add(32'h0020E463, 4'd6, 4'd4, 32'h8, 1'b0);
    add(32'h0020A463, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'hFE208EE3, 4'd6, 4'd1, 32'hFFFFFFFC, 1'b0);
    add(32'hFFC12183, 4'd7, 4'd0, 32'hFFFFFFFC, 1'b1);
    add(32'hFFC13183, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'h00208023, 4'd8, 4'd0, 32'h0, 1'b0);
    add(32'hFE20BE23, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'h00309093, 4'd1, 4'd2, 32'h3, 1'b1);
    add(32'h4030D093, 4'd1, 4'd7, 32'h403, 1'b1);
    add(32'h0010D113, 4'd1, 4'd6, 32'h1, 1'b1);
    add(32'h40309093, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'hFFF0A113, 4'd1, 4'd3, 32'hFFFFFFFF, 1'b1);
    add(32'h0010E113, 4'd1, 4'd8, 32'h1, 1'b1);
    add(32'h0FF0F113, 4'd1, 4'd9, 32'hFF, 1'b1);
    add(32'h0FF0C013, 4'd1, 4'd5, 32'hFF, 1'b0);
    add(32'h0020F1B3, 4'd0, 4'd9, 32'h0, 1'b1);
    add(32'h4020F1B3, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'h4020D1B3, 4'd0, 4'd7, 32'h0, 1'b1);
    add(32'h0020B1B3, 4'd0, 4'd4, 32'h0, 1'b1);
    add(32'h022081B3, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'h0FF0000F, 4'd9, 4'd0, 32'h0, 1'b0);
    add(32'h00000073, 4'd10, 4'd0, 32'h0, 1'b0);
    add(32'h00100073, 4'd11, 4'd0, 32'h0, 1'b0);
    add(32'h00500090, 4'd15, 4'd0, 32'h0, 1'b0);
    add(32'h0000007F, 4'd15, 4'd0, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check_eq("rst_valid", {31'b0, bus.id_valid}, 32'd0);
    check_eq("rst_pc", bus.id_pc, RST_PC);
    check_eq("rst_instr", bus.id_instr, 32'h00000013);
    check_eq("rst_ready", {31'b0, bus.fetch_ready}, 32'd1);
    check_eq("rst_class", {28'b0, bus.id_class}, 32'd1);
    check_eq("rst_alu", {28'b0, bus.id_alu_op}, 32'd0);
    check_eq("rst_rd_we", {31'b0, bus.id_rd_we}, 32'd0);
    @(posedge clk); #1;

    // One-cycle latency
    bus.id_ready = 1'b1;
    send(32'h100, 0);
    @(negedge clk);
    check_eq("lat_valid", {31'b0, bus.id_valid}, 32'd1);
    check_eq("lat_pc", bus.id_pc, 32'h100);
    @(posedge clk); #1;
    drain();

    // Full table with random backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < tbl.size(); i++) send(32'h200 + 32'(4 * i), i);
    rnd_bp = 1'b0;
    drain();

    // Back-to-back full throughput
    for (int i = 0; i < 8; i++) send(32'h280 + 32'(4 * i), i);
    drain();

    // Backpressure holds the entry
    bus.id_ready = 1'b0;
    drive(32'h300, 0);
    @(negedge clk);
    check_eq("bp_ready_first", {31'b0, bus.fetch_ready}, 32'd1);
    @(posedge clk); #1;
`ifdef RV32I_ID_SKID_EN
    drive(32'h304, 1);
    @(negedge clk);
    check_eq("bp_ready_skid", {31'b0, bus.fetch_ready}, 32'd1);
    @(posedge clk); #1;
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("bp_ready_full", {31'b0, bus.fetch_ready}, 32'd0);
      check_eq("bp_valid", {31'b0, bus.id_valid}, 32'd1);
      check_eq("bp_pc", bus.id_pc, 32'h300);
      check_eq("bp_instr", bus.id_instr, tbl[0].instr);
      @(posedge clk); #1;
    end
    drain();

    // Stall freezes both sides
    bus.id_ready = 1'b0;
    send(32'h400, 2);
    stall = 1'b1;
    bus.id_ready = 1'b1;
    drive(32'h404, 3);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("stall_valid", {31'b0, bus.id_valid}, 32'd1);
      check_eq("stall_ready", {31'b0, bus.fetch_ready}, 32'd0);
      check_eq("stall_pc", bus.id_pc, 32'h400);
      @(posedge clk); #1;
    end
    stall = 1'b0;
    drain();

    // Flush discards held and incoming
    bus.id_ready = 1'b0;
    send(32'h500, 4);
`ifdef RV32I_ID_SKID_EN
    send(32'h504, 5);
`endif
    drive(32'h508, 6);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.fetch_valid = 1'b0;
    @(negedge clk);
    check_eq("flush_valid", {31'b0, bus.id_valid}, 32'd0);
    check_eq("flush_ready", {31'b0, bus.fetch_ready}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("flush_hold", {31'b0, bus.id_valid}, 32'd0);
    @(posedge clk); #1;
    bus.id_ready = 1'b1;
    send(32'h600, 7);
    drain();

    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
